// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, branch conditions, flag indices and the
// memory image name shared by the WISC-F24 core.
package cpu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam logic [2:0] CC_NE   = 3'b000;
  localparam logic [2:0] CC_EQ   = 3'b001;
  localparam logic [2:0] CC_GT   = 3'b010;
  localparam logic [2:0] CC_LT   = 3'b011;
  localparam logic [2:0] CC_GTE  = 3'b100;
  localparam logic [2:0] CC_LTE  = 3'b101;
  localparam logic [2:0] CC_OVFL = 3'b110;
  localparam logic [2:0] CC_ALW  = 3'b111;

  localparam int FLG_Z = 0;
  localparam int FLG_V = 1;
  localparam int FLG_N = 2;

  localparam string MEM_IMAGE = "loadfile_all.img";

  function automatic logic cond_met(
    input logic [2:0] ccc,
    input logic [2:0] f
  );
    logic z, v, n, r;
    z = f[FLG_Z];
    v = f[FLG_V];
    n = f[FLG_N];
    r = 1'b1;
    unique case (ccc)
      CC_NE:   r = ~z;
      CC_EQ:   r = z;
      CC_GT:   r = ~z & ~n;
      CC_LT:   r = n;
      CC_GTE:  r = z | ~n;
      CC_LTE:  r = z | n;
      CC_OVFL: r = v;
      CC_ALW:  r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: ADD/SUB/XOR/RED/shift/PADDSB datapath and flags.
// With CPU_SATURATE_EN, ADD/SUB clamp on signed overflow.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic [3:0]  sh_i,
  output logic [15:0] res_o,
  output logic        z_o,
  output logic        v_o,
  output logic        n_o
);

  logic [15:0] sum, dif, pad;
  logic [9:0]  red;
  logic        sum_ov, dif_ov;
  logic [3:0]  nx, ny, ns;

  assign sum    = a_i + b_i;
  assign dif    = a_i - b_i;
  assign sum_ov = (a_i[15] == b_i[15]) && (sum[15] != a_i[15]);
  assign dif_ov = (a_i[15] != b_i[15]) && (dif[15] != a_i[15]);

  assign red = {{2{a_i[15]}}, a_i[15:8]}
             + {{2{a_i[7]}},  a_i[7:0]}
             + {{2{b_i[15]}}, b_i[15:8]}
             + {{2{b_i[7]}},  b_i[7:0]};

  // each nibble clamps to +7 / -8 on its own overflow
  always_comb begin
    pad = '0;
    nx  = '0;
    ny  = '0;
    ns  = '0;
    for (int i = 0; i < 4; i++) begin
      nx = a_i[4*i +: 4];
      ny = b_i[4*i +: 4];
      ns = nx + ny;
      if (nx[3] == ny[3] && ns[3] != nx[3])
        ns = nx[3] ? 4'h8 : 4'h7;
      pad[4*i +: 4] = ns;
    end
  end

  always_comb begin
    res_o = '0;
    v_o   = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o = sum;
        v_o   = sum_ov;
      end
      OP_SUB: begin
        res_o = dif;
        v_o   = dif_ov;
      end
      OP_XOR:    res_o = a_i ^ b_i;
      OP_RED:    res_o = {{6{red[9]}}, red};
      OP_SLL:    res_o = a_i << sh_i;
      OP_SRA:    res_o = $signed(a_i) >>> sh_i;
      OP_ROR:    res_o = 16'({a_i, a_i} >> sh_i);
      OP_PADDSB: res_o = pad;
      default:   res_o = '0;
    endcase
`ifdef CPU_SATURATE_EN
    if (v_o)
      res_o = a_i[15] ? 16'h8000 : 16'h7FFF;
`endif
  end

  assign z_o = (res_o == 16'h0000);
  assign n_o = res_o[15];

endmodule

// File: rtl/cpu_memory.sv
// cpu_memory: 32K x 16 unified memory, async read, sync write.
// Shared by the instruction and data paths of the core.
module cpu_memory
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic [15:0] i_addr_i,
  output logic [15:0] i_data_o,
  input  logic [15:0] d_addr_i,
  input  logic [15:0] d_wdata_i,
  input  logic        d_re_i,
  input  logic        d_we_i,
  output logic [15:0] d_rdata_o,
  output logic        i_stall_o,
  output logic        d_stall_o
);

  logic [15:0] mem_q [32768];
  logic [15:0] i_addr, d_addr, data_in, d_data_out;
  logic        i_read_en, d_read_en, d_write_en;
  logic        i_stall, d_stall, unused_lsb;

  assign i_addr     = i_addr_i;
  assign d_addr     = d_addr_i;
  assign data_in    = d_wdata_i;
  assign i_read_en  = 1'b1;
  assign d_read_en  = d_re_i;
  assign d_write_en = d_we_i;
  assign i_stall    = 1'b0;
  assign d_stall    = 1'b0;
  assign i_stall_o  = i_stall;
  assign d_stall_o  = d_stall;

  assign unused_lsb = i_addr[0] ^ d_addr[0];

  assign i_data_o   = i_read_en ? mem_q[i_addr[15:1]] : 16'h0;
  assign d_data_out = d_read_en ? mem_q[d_addr[15:1]] : 16'h0;
  assign d_rdata_o  = d_data_out;

  always_ff @(posedge clk) begin
    if (d_write_en)
      mem_q[d_addr[15:1]] <= data_in;
  end

endmodule

// File: rtl/cpu_regfile.sv
// cpu_regfile: 16x16 register file, R0 hardwired to zero,
// two async read ports returning pre-write values.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [3:0]  wa_i,
  input  logic [15:0] wd_i,
  input  logic [3:0]  ra1_i,
  input  logic [3:0]  ra2_i,
  output logic [15:0] rd1_o,
  output logic [15:0] rd2_o
);

  logic        write_reg;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data;
  logic [15:0] regs_q [16];

  assign write_reg = we_i;
  assign dst_reg   = wa_i;
  assign dst_data  = wd_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++)
        regs_q[i] <= '0;
    end else if (write_reg && dst_reg != 4'd0) begin
      regs_q[dst_reg] <= dst_data;
    end
  end

  assign rd1_o = (ra1_i == 4'd0) ? 16'h0 : regs_q[ra1_i];
  assign rd2_o = (ra2_i == 4'd0) ? 16'h0 : regs_q[ra2_i];

endmodule

// File: rtl/cpu.sv
// cpu: single-cycle 16-bit WISC-F24 core, one instr per clock.
// Macros: CPU_SATURATE_EN (ADD/SUB clamp), CPU_MEM_INIT.
module cpu
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] pc,
  output logic        hlt
);

  logic [15:0] pc_q, pc_d, pc_inc, br_tgt, addr;
  logic [2:0]  flg_q, flg_d;
  logic [15:0] instr, rs_data, rb_data;
  logic [15:0] alu_res, mem_rdata, wdata;
  logic [3:0]  op, rd, rs, rt, ra2;
  logic        mem_read, mem_write, halt;
  logic        wr_rd, commit, taken;
  logic        i_stall, d_stall;
  logic        alu_z, alu_v, alu_n;

  assign op = instr[15:12];
  assign rd = instr[11:8];
  assign rs = instr[7:4];
  assign rt = instr[3:0];

  assign halt   = (op == OP_HLT);
  assign hlt    = halt & ~rst;
  assign pc     = pc_q;
  assign commit = ~rst & ~halt & ~i_stall & ~d_stall;

  assign mem_read  = (op == OP_LW);
  assign mem_write = (op == OP_SW) & commit;

  // SW stores R[rd]; LLB/LHB merge into R[rd]
  assign ra2 = (op == OP_SW || op == OP_LLB || op == OP_LHB)
             ? rd : rt;

  assign addr   = (rs_data & 16'hFFFE)
                + {{11{instr[3]}}, instr[3:0], 1'b0};
  assign pc_inc = pc_q + 16'd2;
  assign br_tgt = pc_inc + {{6{instr[8]}}, instr[8:0], 1'b0};
  assign taken  = cond_met(instr[11:9], flg_q);

  always_comb begin
    wr_rd = 1'b0;
    wdata = alu_res;
    pc_d  = pc_inc;
    flg_d = flg_q;
    unique case (1'b1)
      op inside {OP_ADD, OP_SUB}: begin
        wr_rd        = 1'b1;
        flg_d[FLG_Z] = alu_z;
        flg_d[FLG_V] = alu_v;
        flg_d[FLG_N] = alu_n;
      end
      op inside {OP_XOR, OP_SLL, OP_SRA, OP_ROR}: begin
        wr_rd        = 1'b1;
        flg_d[FLG_Z] = alu_z;
      end
      op inside {OP_RED, OP_PADDSB}: wr_rd = 1'b1;
      op == OP_LW: begin
        wr_rd = 1'b1;
        wdata = mem_rdata;
      end
      op == OP_LLB: begin
        wr_rd = 1'b1;
        wdata = {rb_data[15:8], instr[7:0]};
      end
      op == OP_LHB: begin
        wr_rd = 1'b1;
        wdata = {instr[7:0], rb_data[7:0]};
      end
      op == OP_B: begin
        if (taken) pc_d = br_tgt;
      end
      op == OP_BR: begin
        if (taken) pc_d = rs_data;
      end
      op == OP_PCS: begin
        wr_rd = 1'b1;
        wdata = pc_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      flg_q <= '0;
    end else if (commit) begin
      pc_q  <= pc_d;
      flg_q <= flg_d;
    end
  end

  cpu_regfile regfile (
    .clk   (clk),
    .rst   (rst),
    .we_i  (wr_rd & commit),
    .wa_i  (rd),
    .wd_i  (wdata),
    .ra1_i (rs),
    .ra2_i (ra2),
    .rd1_o (rs_data),
    .rd2_o (rb_data)
  );

  cpu_alu alu (
    .op_i  (op),
    .a_i   (rs_data),
    .b_i   (rb_data),
    .sh_i  (instr[3:0]),
    .res_o (alu_res),
    .z_o   (alu_z),
    .v_o   (alu_v),
    .n_o   (alu_n)
  );

  cpu_memory memory_inst (
    .clk       (clk),
    .i_addr_i  (pc_q),
    .i_data_o  (instr),
    .d_addr_i  (addr),
    .d_wdata_i (rb_data),
    .d_re_i    (mem_read),
    .d_we_i    (mem_write),
    .d_rdata_o (mem_rdata),
    .i_stall_o (i_stall),
    .d_stall_o (d_stall)
  );

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs; register/memory writes are checked
// against a queue of expected events by an independent monitor.
module tb_cpu;

  typedef struct {
    bit          is_mem;
    logic [15:0] addr;
    logic [15:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc;
  logic        hlt;

  int errors = 0;
  int checks = 0;

  ev_t         sb[$];
  logic [15:0] prog[$];
  logic [15:0] tr[64];
  int          ntr;

  cpu dut (
    .clk (clk),
    .rst (rst),
    .pc  (pc),
    .hlt (hlt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic void exp_reg(input logic [3:0] r,
                                  input logic [15:0] d);
    sb.push_back('{1'b0, {12'h0, r}, d});
  endfunction

  function automatic void exp_mem(input logic [15:0] a,
                                  input logic [15:0] d);
    sb.push_back('{1'b1, a, d});
  endfunction

  task automatic observe(input bit m,
                         input logic [15:0] a,
                         input logic [15:0] d);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_extra: got mem=%0d %h=%h want none",
               m, a, d);
    end else begin
      e = sb.pop_front();
      if (e.is_mem != m || e.addr !== a || e.data !== d) begin
        errors++;
        $display("FAIL sb_write: got mem=%0d %h=%h want mem=%0d %h=%h",
                 m, a, d, e.is_mem, e.addr, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (dut.regfile.write_reg && dut.regfile.dst_reg != 4'd0)
        observe(1'b0, {12'h0, dut.regfile.dst_reg},
                dut.regfile.dst_data);
      if (dut.mem_write)
        observe(1'b1, dut.memory_inst.d_addr,
                dut.memory_inst.data_in);
    end
  end

  task automatic run(input string nm,
                     input logic [15:0] halt_pc,
                     input int hold);
    bit done;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < prog.size(); i++)
      dut.memory_inst.mem_q[i] = prog[i];
    @(posedge clk); #1;
    chk({nm, "_rst_pc"}, pc, 16'h0000);
    chk({nm, "_rst_hlt"}, {15'h0, hlt}, 16'h0000);
    rst  = 1'b0;
    ntr  = 0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (ntr < 64) begin
        tr[ntr] = pc;
        ntr++;
      end
      done = hlt;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: got no hlt want hlt", nm);
    end
    chk({nm, "_halt_pc"}, pc, halt_pc);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk({nm, "_hold_pc"}, pc, halt_pc);
      chk({nm, "_hold_hlt"}, {15'h0, hlt}, 16'h0001);
    end
    chk({nm, "_sb_left"}, 16'(sb.size()), 16'h0000);
    sb.delete();
  endtask

  initial begin
    // LLB/LHB build, ADD overflow, B LT on N, B OVFL on V
    prog = '{16'hA134, 16'hB112, 16'hA1FF, 16'hB17F,
             16'hA201, 16'h0612, 16'hC602, 16'hA711,
             16'hA822, 16'hCC01, 16'hA955, 16'hF000};
    exp_reg(4'd1, 16'h0034);
    exp_reg(4'd1, 16'h1234);
    exp_reg(4'd1, 16'h12FF);
    exp_reg(4'd1, 16'h7FFF);
    exp_reg(4'd2, 16'h0001);
`ifdef CPU_SATURATE_EN
    exp_reg(4'd6, 16'h7FFF);
    exp_reg(4'd7, 16'h0011);
    exp_reg(4'd8, 16'h0022);
`else
    exp_reg(4'd6, 16'h8000);
`endif
    run("p1", 16'h0016, 0);
    chk("p1_pc_first", tr[0], 16'h0000);
    chk("p1_pc_third", tr[2], 16'h0004);
`ifdef CPU_SATURATE_EN
    chk("p1_blt_next", tr[7], 16'h000E);
`else
    chk("p1_blt_next", tr[7], 16'h0012);
`endif

    // SW then LW through the same address, HLT at 0x000A
    prog = '{16'hA3EF, 16'hB3BE, 16'hAA10, 16'h93A2,
             16'h84A2, 16'hF000};
    exp_reg(4'd3, 16'h00EF);
    exp_reg(4'd3, 16'hBEEF);
    exp_reg(4'd10, 16'h0010);
    exp_mem(16'h0014, 16'hBEEF);
    exp_reg(4'd4, 16'hBEEF);
    run("p2", 16'h000A, 10);
    chk("p2_mem_word", dut.memory_inst.mem_q[10], 16'hBEEF);

    // branches on Z, PADDSB, XOR, PCS, RED, shifts, BR
    prog = '{16'hA107, 16'h1511, 16'hC203, 16'hAB01,
             16'hAB02, 16'hAB03, 16'hC003, 16'hAC77,
             16'hBC77, 16'hAD11, 16'hBD11, 16'h7ECD,
             16'h7FDD, 16'h22CC, 16'hC401, 16'hE900,
             16'h38CD, 16'h47D4, 16'h6688, 16'hB580,
             16'h5653, 16'hAA30, 16'hDEA0, 16'hAB99,
             16'hF000};
    exp_reg(4'd1, 16'h0007);
    exp_reg(4'd5, 16'h0000);
    exp_reg(4'd12, 16'h0077);
    exp_reg(4'd12, 16'h7777);
    exp_reg(4'd13, 16'h0011);
    exp_reg(4'd13, 16'h1111);
    exp_reg(4'd14, 16'h7777);
    exp_reg(4'd15, 16'h2222);
    exp_reg(4'd2, 16'h0000);
    exp_reg(4'd9, 16'h0020);
    exp_reg(4'd8, 16'h0110);
    exp_reg(4'd7, 16'h1110);
    exp_reg(4'd6, 16'h1001);
    exp_reg(4'd5, 16'h8000);
    exp_reg(4'd6, 16'hF000);
    exp_reg(4'd10, 16'h0030);
    run("p3", 16'h0030, 0);
    chk("p3_beq_pc", tr[2], 16'h0004);
    chk("p3_beq_next", tr[3], 16'h000C);
    chk("p3_bne_next", tr[4], 16'h000E);

    // HLT at address 0: hlt must stay low while rst is high
    prog = '{16'hF000};
    run("p4", 16'h0000, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
